// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   state_e   - scanner FSM states (scan, debounce, held, release)
//   key_map   - (row, col) -> hex key code for the physical keypad layout
//   low_col   - index of the single low bit in an active-low column pattern
//   single_low- true when exactly one column line is pulled low
//   row_drive - active-low one-cold row drive pattern for a row index
package keypad_pkg;

  localparam int unsigned NumRows = 4;
  localparam int unsigned NumCols = 4;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StDebounce = 2'd1,
    StHeld     = 2'd2,
    StRelease  = 2'd3
  } state_e;

  // Physical layout, col0 leftmost:
  //   row0: 1 2 3 A
  //   row1: 4 5 6 B
  //   row2: 7 8 9 C
  //   row3: E 0 F D
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    unique case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
    endcase
    return code;
  endfunction

  // Only meaningful when the pattern has exactly one low bit.
  function automatic logic [1:0] low_col(input logic [3:0] pattern);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NumCols; i++) begin
      if (!pattern[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic single_low(input logic [3:0] pattern);
    logic [2:0] n_low;
    n_low = 3'd0;
    for (int i = 0; i < NumCols; i++) begin
      n_low = n_low + {2'b00, ~pattern[i]};
    end
    return n_low == 3'd1;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: signals between the scanner and the keypad/consumer side.
//   cols      - raw active-low column lines from the keypad (async to clk)
//   rows      - active-low one-cold row drive
//   key_code  - hex code of the last accepted key
//   key_valid - one-cycle pulse on acceptance of a new key
//   key_down  - high while the accepted key is still held (incl. release debounce)
// master: the scanner; slave: the keypad plus whoever consumes the key events.
interface keypad_scanner_if;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  cols,
    output rows,
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    output cols,
    input  rows,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs.
//   clk      - destination clock
//   reset    - synchronous active-low reset, loads RESET_VAL into both flops
//   i_async  - asynchronous input bus
//   o_sync   - synchronized output, two cycles behind i_async
module sync_2ff #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press and
// release, and reports one event per accepted key.
//   clk       - system clock, all state on the rising edge
//   reset     - synchronous active-low reset
//   kp.cols   - raw column lines (async), synchronized before use
//   kp.rows   - one-cold row drive, registered
//   kp.key_code / kp.key_valid / kp.key_down - registered key outputs
// Every output is a flop, so there is no combinational path from cols.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic               clk,
  input  logic               reset,
  keypad_scanner_if.master   kp
);

  localparam int unsigned DwellW  = $clog2(SCAN_CYCLES) + 1;
  localparam int unsigned StableW = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [DwellW-1:0]  DwellLast  = DwellW'(SCAN_CYCLES - 1);
  localparam logic [StableW-1:0] StableLast = StableW'(DEBOUNCE_CYCLES - 1);

  state_e              r_state;
  logic [1:0]          r_row;
  logic [3:0]          r_rows;
  logic [3:0]          r_pat;
  logic [3:0]          r_code;
  logic                r_valid;
  logic                r_down;
  logic [DwellW-1:0]   r_dwell;
  logic [StableW-1:0]  r_stable;

  logic [3:0]          w_scols;
  logic [1:0]          w_row_next;
  logic                w_one_low;
  logic                w_all_high;
  logic                w_match;
  logic [DwellW-1:0]   w_dwell_inc;
  logic [StableW-1:0]  w_stable_inc;

  // Idle lines read high, so the synchronizer resets to "no key".
  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (4'b1111)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (kp.cols),
    .o_sync  (w_scols)
  );

  assign w_row_next = r_row + 2'd1;
  assign w_one_low  = single_low(w_scols);
  assign w_all_high = (w_scols == 4'b1111);
  assign w_match    = (w_scols == r_pat);

  // Counters stop at all-ones rather than wrapping.
  assign w_dwell_inc  = (r_dwell == '1) ? r_dwell : r_dwell + 1'b1;
  assign w_stable_inc = (r_stable == '1) ? r_stable : r_stable + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= StScan;
      r_row    <= 2'd0;
      r_rows   <= 4'b1110;
      r_pat    <= 4'b1111;
      r_code   <= 4'h0;
      r_valid  <= 1'b0;
      r_down   <= 1'b0;
      r_dwell  <= '0;
      r_stable <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        StScan: begin
          if (r_dwell == DwellLast) begin
            if (w_one_low) begin
              // Keep driving this row while the candidate is confirmed.
              r_pat    <= w_scols;
              r_stable <= '0;
              r_state  <= StDebounce;
            end else begin
              r_row   <= w_row_next;
              r_rows  <= row_drive(w_row_next);
              r_dwell <= '0;
            end
          end else begin
            r_dwell <= w_dwell_inc;
          end
        end

        StDebounce: begin
          if (w_match) begin
            if (r_stable == StableLast) begin
              r_valid <= 1'b1;
              r_down  <= 1'b1;
              r_code  <= key_map(r_row, low_col(r_pat));
              r_state <= StHeld;
            end else begin
              r_stable <= w_stable_inc;
            end
          end else begin
            r_row   <= w_row_next;
            r_rows  <= row_drive(w_row_next);
            r_dwell <= '0;
            r_state <= StScan;
          end
        end

        StHeld: begin
          // Extra keys on the held row are ignored; only a full release counts.
          if (w_all_high) begin
            r_stable <= '0;
            r_state  <= StRelease;
          end
        end

        StRelease: begin
          if (w_all_high) begin
            if (r_stable == StableLast) begin
              r_down  <= 1'b0;
              r_row   <= w_row_next;
              r_rows  <= row_drive(w_row_next);
              r_dwell <= '0;
              r_state <= StScan;
            end else begin
              r_stable <= w_stable_inc;
            end
          end else begin
            r_state <= StHeld;
          end
        end
      endcase
    end
  end

  assign kp.rows      = r_rows;
  assign kp.key_code  = r_code;
  assign kp.key_valid = r_valid;
  assign kp.key_down  = r_down;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 1000; clock cycles each row is driven before sampling and advancing; legal range >= 4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000; consecutive stable cycles required to accept a press or a release; legal range >= 2.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 cols  input  4  raw keypad column lines, active-low (pulled up; 0 = contact to the driven row); asynchronous to clk.
REQ-006 rows  output  4  keypad row drive, active-low one-cold; exactly one bit is 0 at all times.
REQ-007 key_code  output  4  hex value of the last accepted key; holds until the next accepted key.
REQ-008 key_valid  output  1  one-cycle pulse marking acceptance of a new key.
REQ-009 key_down  output  1  high while an accepted key is still held, including its release debounce.

Function
REQ-010 cols SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (scols), giving 2 cycles of input latency.
REQ-011 Key map (row,col)->code, row0: 1 2 3 A; row1: 4 5 6 B; row2: 7 8 9 C; row3: E 0 F D (col0 leftmost).
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 SCAN: drive rows = ~(1<<row_idx); dwell counter counts 0..SCAN_CYCLES-1; scols sampled only in the last dwell cycle.
REQ-014 SCAN, sample with exactly one scols bit low: latch row_idx and the column pattern; go to DEBOUNCE; rows unchanged.
REQ-015 SCAN, sample with zero or >=2 scols bits low: row_idx advances (3 wraps to 0); dwell restarts; no output change.
REQ-016 DEBOUNCE: stable counter increments each cycle scols equals the latched pattern; any mismatch returns to SCAN with row_idx advanced, no pulse.
REQ-017 DEBOUNCE reaching DEBOUNCE_CYCLES stable cycles: next cycle key_valid=1 for exactly one cycle, key_code=mapped code, key_down=1, state HELD.
REQ-018 HELD: latched row stays driven; scols all-high moves to RELEASE with stable counter cleared; any other pattern (extra keys, other columns) is ignored, with no roll-over.
REQ-019 RELEASE: counter increments while scols all-high; any low bit returns to HELD with no new pulse.
REQ-020 RELEASE reaching DEBOUNCE_CYCLES: key_down=0, row_idx advances, state SCAN, dwell restarts.
REQ-021 key_valid SHALL never assert on two consecutive cycles; a continuously held key SHALL produce exactly one pulse.
REQ-022 Counters SHALL be sized $clog2 of their parameter +1 and SHALL saturate, never wrap.

Reset
REQ-023 While reset=0 at a rising edge, next-state values: state SCAN, row_idx 0, rows 4'b1110, key_code 4'h0, key_valid 0, key_down 0, all counters and synchronizer flops cleared (synchronizer to 4'b1111).
REQ-024 Reset asserted in any state, including mid-DEBOUNCE or HELD, SHALL take effect on that edge with no pulse emitted.

Structure
REQ-025 Package keypad_pkg SHALL hold the state enum type and the 4x4 key-map constant/function; the module imports it.
REQ-026 The 2-flop synchronizer SHALL be a sub-module named sync_2ff (width-parameterized, same clk/reset).
REQ-027 The block SHALL contain no latches and no combinational path from cols to any output.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8; the bench models the keypad by pulling cols bit low only while its row is driven)
REQ-028 Reset: hold reset=0 for 2 cycles -> rows=4'b1110, key_code=0, key_valid=0, key_down=0.
REQ-029 Idle: cols=4'b1111 for 32 cycles -> rows sequences 1110,1101,1011,0111,1110, each for 4 cycles; key_valid stays 0.
REQ-030 Press "5" (row1,col1) held 40 cycles -> exactly one key_valid pulse, key_code=4'h5, rows frozen at 4'b1101, key_down=1; after release and 8 stable cycles key_down=0 and scanning resumes at row2.
REQ-031 Bounce: "9" toggled every 3 cycles for 20 cycles, then held stable -> no pulse during bounce; one pulse with key_code=4'h9 after 8 stable cycles.
REQ-032 Multi-key: "1" and "2" pressed together -> no pulse; while "D" is held, press "0" too -> no second pulse, key_code stays 4'hD.
REQ-033 Reset mid-HELD with "A" pressed -> next edge rows=4'b1110, key_down=0, key_code=0; after reset is released, "A" is re-accepted with one pulse.
